lc3_writeback_unit: RTL and testbench
=====================================

// Module: lc3_writeback_unit
// PURPOSE
//  Sink end of the LC-3 ALU result path: accepts {result, DR, setcc} over valid/ready,
//  buffers in a small FIFO, commits to the 8x16 register file, updates NZP condition codes.
//  Provides the two combinational source-register read ports that feed the ALU A/B operands.
//  Sits between ALU/MDR result muxing and the register file in the lab datapath.
// PARAMETERS
//  DATA_W      16  register/result width
//  NUM_REGS    8   register file entries (DR/SR width = $clog2(NUM_REGS) = 3)
//  FIFO_DEPTH  2   pending-writeback buffer entries (power of 2, >=2)
// PORTS
//  Clk        in   1       rising-edge clock
//  Reset      in   1       asynchronous, active-high reset
//  res_valid  in   1       result offered this cycle
//  res_ready  out  1       unit can accept a result this cycle
//  res_data   in   16      result value
//  res_dr     in   3       destination register
//  res_setcc  in   1       update NZP when this entry commits
//  wb_stall   in   1       inhibit commit this cycle (FIFO holds)
//  SR1, SR2   in   3 each  read addresses
//  SR1_OUT    out  16      regfile[SR1] (see CONFIGURATION)
//  SR2_OUT    out  16      regfile[SR2] (see CONFIGURATION)
//  NZP        out  3       {N,Z,P} condition codes
//  pending    out  2       FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transfer): all regs=16'h0000, NZP=3'b010, FIFO empty,
//    pending=0, res_ready=1; in-flight entries discarded, no commit.
//  - res_ready = (pending < FIFO_DEPTH); combinational from occupancy only, never from res_valid.
//  - Push: res_valid & res_ready at edge k -> entry enters FIFO tail at k.
//  - Commit: at every edge where pending>0 & !wb_stall, head entry pops:
//    regfile[dr]<=data; if setcc: N=data[15], Z=(data==0), P=!N&!Z (exactly one bit set).
//  - Latency: push at edge k into empty FIFO -> committed at edge k+1; regfile read shows it
//    after k+1. Throughput 1/cycle with wb_stall=0 (pending stays <=1).
//  - Simultaneous push+pop: both occur; pending unchanged. Full + pop: no push that cycle
//    (ready already low); ready rises the cycle after the pop.
//  - Commits strictly in push order; same-DR back-to-back: later value wins.
//  - setcc=0 entries never touch NZP. Stall holds FIFO, regfile, NZP unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; pending is the full/empty discriminator.
//  - Reads are combinational, no read latency; reads of an address committing this edge
//    return the old value until the edge.
// CONFIGURATION
//  WB_BYPASS_EN defined: SRx_OUT returns data of the YOUNGEST FIFO entry with dr==SRx,
//    else regfile[SRx] (read-after-write forwarding across pending writes).
//  WB_BYPASS_EN undefined: SRx_OUT = regfile[SRx] only; pending writes invisible until commit.
// TESTING
//  1 Reset: assert Reset mid-stream with pending=2 -> all SR reads 0, NZP=010, pending=0, ready=1.
//  2 Single write: push {16'h8001,DR=3,setcc=1} -> next edge R3=16'h8001, NZP=100;
//    push {0,DR=3,setcc=1} -> R3=0, NZP=010; push {5,DR=3,setcc=0} -> NZP stays 010.
//  3 Stall/full: wb_stall=1, push 16'h0011->R1, 16'h0022->R2 -> pending=2, res_ready=0, third
//    valid ignored; release stall -> R1 then R2 commit in order, ready high after first pop.
//  4 Streaming: wb_stall=0, push 8 results back-to-back (R0..R7=i*16'h1111) -> pending<=1,
//    ready never drops, all regs correct 1 cycle after each push.
//  5 WAW ordering: stall, push 16'hAAAA->R4 then 16'h5555->R4, release -> R4=16'h5555, NZP=001.
//  6 Bypass: stall, push 16'h1234->R6 then 16'h4321->R6, SR1=6 -> with WB_BYPASS_EN
//    SR1_OUT=16'h4321 immediately; without it SR1_OUT=old R6 until commit.

Source files
------------

// File: rtl/lc3_writeback_unit_if.sv
// Result handshake bundle between the ALU/MDR result mux (master) and the
// writeback unit (slave): one {data, dr, setcc} result per valid&ready edge.
interface lc3_writeback_unit_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [AW-1:0]     dr;
  logic              setcc;

  modport master (output valid, data, dr, setcc, input ready);
  modport slave  (input valid, data, dr, setcc, output ready);
endinterface

// File: rtl/lc3_writeback_unit.sv
// LC-3 writeback unit: small result FIFO, 8x16 register file, NZP codes, two read ports.
// Optional macro WB_BYPASS_EN forwards the youngest pending write to the read ports.
module lc3_writeback_unit #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int FIFO_DEPTH = 2,
  localparam int AW = $clog2(NUM_REGS),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  lc3_writeback_unit_if.slave res,
  input  logic                wb_stall_i,
  input  logic [AW-1:0]       sr1_i,
  input  logic [AW-1:0]       sr2_i,
  output logic [DATA_W-1:0]   sr1_out_o,
  output logic [DATA_W-1:0]   sr2_out_o,
  output logic [2:0]          nzp_o,
  output logic [CW-1:0]       pending_o
);

  logic [DATA_W-1:0] rf_q        [NUM_REGS];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]     fifo_dr_q   [FIFO_DEPTH];
  logic              fifo_sc_q   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              push_s, pop_s;

  // Exactly one of N/Z/P is set for any value.
  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    logic n, z;
    n = v[DATA_W-1];
    z = (v == {DATA_W{1'b0}});
    return {n, z, (!n && !z)};
  endfunction

  // Youngest pending entry targeting sr wins; otherwise the committed value.
  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] sr);
    logic [DATA_W-1:0] val;
`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx;
`endif
    val = rf_q[sr];
`ifdef WB_BYPASS_EN
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_dr_q[idx] == sr)) begin
        val = fifo_data_q[idx];
      end else begin
        val = val;
      end
    end
`endif
    return val;
  endfunction

  assign res.ready = (count_q < CW'(FIFO_DEPTH));
  assign pending_o = count_q;
  assign nzp_o     = nzp_q;

  // Handshake decode and next-state for pointers, occupancy and condition codes.
  always_comb begin
    push_s   = res.valid && res.ready;
    pop_s    = (count_q != {CW{1'b0}}) && !wb_stall_i;
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_s && fifo_sc_q[rd_ptr_q]) begin
      nzp_d = nzp_of(fifo_data_q[rd_ptr_q]);
    end else begin
      nzp_d = nzp_q;
    end
  end

  // Combinational register read ports.
  always_comb begin
    sr1_out_o = read_port(sr1_i);
    sr2_out_o = read_port(sr2_i);
  end

  // FIFO storage, register-file commit and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {DATA_W{1'b0}};
        fifo_dr_q[i]   <= {AW{1'b0}};
        fifo_sc_q[i]   <= 1'b0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      nzp_q    <= 3'b010;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= res.data;
        fifo_dr_q[wr_ptr_q]   <= res.dr;
        fifo_sc_q[wr_ptr_q]   <= res.setcc;
      end
      if (pop_s) begin
        rf_q[fifo_dr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nzp_q    <= nzp_d;
    end
  end

endmodule

// File: tb/tb_lc3_writeback_unit.sv
// Self-checking bench for lc3_writeback_unit: directed scenarios plus random traffic
// checked against a queue-based architectural model of the register file and NZP.
module tb_lc3_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  sr1, sr2;
  logic [15:0] sr1_out, sr2_out;
  logic [2:0]  nzp;
  logic [1:0]  pend;

  always #10 clk = ~clk;

  lc3_writeback_unit_if res ();

  lc3_writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .res        (res),
    .wb_stall_i (stall),
    .sr1_i      (sr1),
    .sr2_i      (sr2),
    .sr1_out_o  (sr1_out),
    .sr2_out_o  (sr2_out),
    .nzp_o      (nzp),
    .pending_o  (pend)
  );

  typedef struct {
    logic [15:0] d;
    logic [2:0]  dr;
    logic        sc;
  } ent_t;

  ent_t        q[$];
  logic [15:0] ref_rf [8];
  logic [2:0]  ref_nzp;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [2:0] a);
    logic [15:0] v;
    v = ref_rf[a];
`ifdef WB_BYPASS_EN
    foreach (q[i]) if (q[i].dr == a) v = q[i].d;
`endif
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
    ref_nzp = 3'b010;
  endtask

  task automatic model_edge();
    ent_t e;
    bit   do_pop;
    bit   do_push;
    do_pop  = (q.size() > 0) && !stall;
    do_push = res.valid && (q.size() < 2);
    if (do_pop) begin
      e = q.pop_front();
      ref_rf[e.dr] = e.d;
      if (e.sc) begin
        if (e.d[15])          ref_nzp = 3'b100;
        else if (e.d == 16'd0) ref_nzp = 3'b010;
        else                  ref_nzp = 3'b001;
      end
    end
    if (do_push) begin
      e.d  = res.data;
      e.dr = res.dr;
      e.sc = res.setcc;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] dr, input logic sc);
    res.valid = v;
    res.data  = d;
    res.dr    = dr;
    res.setcc = sc;
  endtask

  task automatic tick();
    chk("ready", {15'd0, res.ready}, {15'd0, (q.size() < 2)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    chk("pending", {14'd0, pend}, 16'(q.size()));
    chk("nzp", {13'd0, nzp}, {13'd0, ref_nzp});
    chk("sr1_out", sr1_out, ref_read(sr1));
    chk("sr2_out", sr2_out, ref_read(sr2));
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      sr1 = 3'(2 * i);
      sr2 = 3'(2 * i + 1);
      #1;
      chk("rd_a", sr1_out, ref_read(sr1));
      chk("rd_b", sr2_out, ref_read(sr2));
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    sr1 = 3'd0;
    sr2 = 3'd0;
    drive(1'b0, 16'h0000, 3'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pending", {14'd0, pend}, 16'd0);
    chk("rst_ready", {15'd0, res.ready}, 16'd1);
    chk("rst_nzp", {13'd0, nzp}, 16'd2);
    check_regs();
    @(negedge clk);
    rst = 1'b0;

    // Single writes and NZP update rules
    sr1 = 3'd3;
    drive(1'b1, 16'h8001, 3'd3, 1'b1); tick();
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick();
    chk("t2_r3", sr1_out, 16'h8001);
    chk("t2_nzp_n", {13'd0, nzp}, 16'd4);
    drive(1'b1, 16'h0000, 3'd3, 1'b1); tick();
    drive(1'b1, 16'h0005, 3'd3, 1'b0); tick();
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick();
    chk("t2_r3_5", sr1_out, 16'h0005);
    chk("t2_nzp_keep", {13'd0, nzp}, 16'd2);

    // Stall until full; third offer ignored; in-order drain
    stall = 1'b1;
    drive(1'b1, 16'h0011, 3'd1, 1'b1); tick();
    drive(1'b1, 16'h0022, 3'd2, 1'b1); tick();
    chk("t3_pending", {14'd0, pend}, 16'd2);
    chk("t3_ready", {15'd0, res.ready}, 16'd0);
    drive(1'b1, 16'h0033, 3'd5, 1'b1); tick();
    stall = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick();
    chk("t3_ready_after_pop", {15'd0, res.ready}, 16'd1);
    tick();
    check_regs();

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i) * 16'h1111, 3'(i), 1'b1);
      tick();
    end
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick();
    check_regs();

    // WAW ordering
    stall = 1'b1;
    drive(1'b1, 16'hAAAA, 3'd4, 1'b1); tick();
    drive(1'b1, 16'h5555, 3'd4, 1'b1); tick();
    stall = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick(); tick();
    sr1 = 3'd4; #1;
    chk("t5_r4", sr1_out, 16'h5555);
    chk("t5_nzp", {13'd0, nzp}, 16'd1);

    // Read of pending writes (forwarded or not)
    stall = 1'b1;
    sr1 = 3'd6;
    drive(1'b1, 16'h1234, 3'd6, 1'b0); tick();
    drive(1'b1, 16'h4321, 3'd6, 1'b0); tick();
`ifdef WB_BYPASS_EN
    chk("t6_bypass", sr1_out, 16'h4321);
`else
    chk("t6_nobypass", sr1_out, 16'h6666);
`endif
    stall = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 1'b0); tick(); tick();
    chk("t6_r6", sr1_out, 16'h4321);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      sr1 = 3'($urandom_range(0, 7));
      sr2 = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      tick();
    end

    // Async reset mid-stream with a full FIFO
    stall = 1'b1;
    drive(1'b1, 16'h7777, 3'd7, 1'b1); tick();
    drive(1'b1, 16'h8888, 3'd0, 1'b1); tick();
    drive(1'b1, 16'h9999, 3'd1, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_pending", {14'd0, pend}, 16'd0);
    chk("mid_rst_ready", {15'd0, res.ready}, 16'd1);
    chk("mid_rst_nzp", {13'd0, nzp}, 16'd2);
    check_regs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 1'b0);
    tick(); tick();
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
